// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory load/store path: opcodes, store
// queue entry layout, store FSM encoding and the byte-lane merge helper.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } store_entry_t;

    // Store drain FSM encoding, kept as plain constants for legacy compatibility.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;

    // Lane k (bits [8k+7:8k]) comes from new_word where mask[k] is set.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
        logic [31:0] result;
        result = old_word;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) result[8*k +: 8] = new_word[8*k +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/data_mem_store_unit_store_queue.sv
// In-order FIFO of posted stores. The entry array and per-slot valid bits are
// exported so the parent can compare every pending address against loads.
module store_queue
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  store_entry_t        push_entry,
    input  logic                pop,
    output store_entry_t        head,
    output store_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0]    valid,
    output logic [PTR_W:0]      count,
    output logic                full,
    output logic                empty
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the entry storage has no reset; slots are only observed through
    // valid, which is derived from the reset pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset   = PTR_W'(i) - rd_ptr;
            valid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/data_mem_store_unit.sv
// Posted store unit: decodes SB/SH/SW, queues them and drains each one into
// word-addressed memory, read-modify-writing sub-word stores.
module data_mem_store_unit
    import mips_mem_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [31:0]       req_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [ADDR_W-1:0] chk_address,
    output logic              chk_hit,
    output logic              busy,
    output logic              misalign_err
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    state_t             state;
    logic [31:0]        merge_reg;
    store_entry_t       new_entry;
    logic               dec_ok;
    logic               fire;
    logic               q_pop;
    store_entry_t       q_head;
    store_entry_t       q_entries [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_valid;
    logic [PTR_W:0]     q_count;
    logic               q_full;
    logic               q_empty;
    logic [ADDR_W-1:0]  head_byte_addr;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dec_ok              = 1'b0;
        new_entry.word_addr = 30'(req_address[ADDR_W-1:2]);
        new_entry.mask      = 4'b0000;
        new_entry.data      = req_data;
        case (req_opcode)
            OP_SB: begin
                dec_ok         = 1'b1;
                new_entry.mask = 4'b0001 << req_address[1:0];
                new_entry.data = {4{req_data[7:0]}};
            end
            OP_SH: begin
                dec_ok         = !req_address[0];
                new_entry.mask = req_address[1] ? 4'b1100 : 4'b0011;
                new_entry.data = {2{req_data[15:0]}};
            end
            OP_SW: begin
                dec_ok         = (req_address[1:0] == 2'b00);
                new_entry.mask = 4'b1111;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    assign req_ready = !q_full;
    assign fire      = req_valid && req_ready;
    assign q_pop     = (state == ST_WRITE);

    store_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (fire && dec_ok),
        .push_entry (new_entry),
        .pop        (q_pop),
        .head       (q_head),
        .entries    (q_entries),
        .valid      (q_valid),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            merge_reg    <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= fire && !dec_ok;
            case (state)
                ST_IDLE: begin
                    if (!q_empty) state <= (q_head.mask == 4'b1111) ? ST_WRITE : ST_READ;
                end
                ST_READ: begin
                    merge_reg <= mem_rdata;
                    state     <= ST_WRITE;
                end
                ST_WRITE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign head_byte_addr = ADDR_W'({q_head.word_addr, 2'b00});
    assign mem_read       = (state == ST_READ);
    assign mem_write      = (state == ST_WRITE);
    assign mem_address    = (mem_read || mem_write) ? head_byte_addr : '0;
    assign mem_wdata      = mem_write ? lane_merge(merge_reg, q_head.data, q_head.mask) : '0;
    assign busy           = (q_count != '0) || (state != ST_IDLE);

    // Word-granular match against every live entry; byte masks are ignored.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (q_valid[i] &&
                (((ADDR_W'({q_entries[i].word_addr, 2'b00}) ^ chk_address) >> 2) == '0))
                chk_hit = 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_store_unit.sv
// Directed bench for data_mem_store_unit with a small word-addressed memory
// model that reads combinationally and commits writes on the rising edge.
module tb_data_mem_store_unit;

    localparam logic [5:0] SB = 6'h28;
    localparam logic [5:0] SH = 6'h29;
    localparam logic [5:0] SW = 6'h2B;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] chk_address;
    logic        chk_hit;
    logic        busy;
    logic        misalign_err;

    logic [31:0] mem [64];
    int checks;
    int errors;

    data_mem_store_unit #(.QUEUE_DEPTH(2), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_address  (req_address),
        .req_data     (req_data),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .chk_address  (chk_address),
        .chk_hit      (chk_hit),
        .busy         (busy),
        .misalign_err (misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[7:2]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (mem_read && mem_write) begin
                errors++;
                $display("FAIL rd_wr_exclusive: mem_read=%b mem_write=%b required not both", mem_read, mem_write);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
        req_valid   = 1'b1;
        req_opcode  = op;
        req_address = addr;
        req_data    = data;
    endtask

    task automatic idle_req();
        req_valid   = 1'b0;
        req_opcode  = 6'h00;
        req_address = 32'h0;
        req_data    = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({req_ready, mem_read, mem_write, chk_hit, busy, misalign_err} !== 6'b100000) begin
            errors++;
            $display("FAIL %s_flags: got %b required 100000", tag,
                     {req_ready, mem_read, mem_write, chk_hit, busy, misalign_err});
        end
        checks++;
        if ({mem_address, mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL %s_buses: got addr=%h wdata=%h required 0/0", tag, mem_address, mem_wdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_req();
        chk_address = 32'h0;
        #12;
        check_reset_outputs("reset");
        step();
        reset = 1'b0;
        step();
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_sb();
        drive(SB, 32'h12, 32'h0000_00AB);
        step();  // E0
        idle_req();
        checks++;
        if ({busy, misalign_err} !== 2'b10) begin
            errors++; $display("FAIL sb_accept: busy,misalign=%b required 10", {busy, misalign_err});
        end
        step();  // E1: READ
        checks++;
        if ({mem_read, mem_write, mem_address} !== {2'b10, 32'h10}) begin
            errors++; $display("FAIL sb_read: rd=%b wr=%b addr=%h required 1 0 00000010", mem_read, mem_write, mem_address);
        end
        step();  // E2: WRITE
        checks++;
        if ({mem_read, mem_write, mem_wdata} !== {2'b01, 32'h11AB_3344}) begin
            errors++; $display("FAIL sb_write: rd=%b wr=%b wdata=%h required 0 1 11ab3344", mem_read, mem_write, mem_wdata);
        end
        checks++;
        if (mem[4] !== 32'h1122_3344) begin
            errors++; $display("FAIL sb_mem_early: got %h required 11223344", mem[4]);
        end
        step();  // E3
        checks++;
        if ({mem[4], busy} !== {32'h11AB_3344, 1'b0}) begin
            errors++; $display("FAIL sb_mem_commit: mem=%h busy=%b required 11ab3344 0", mem[4], busy);
        end
    endtask

    task automatic test_sh();
        drive(SH, 32'h16, 32'h0000_1234);
        step();
        idle_req();
        step();
        checks++;
        if (mem_read !== 1'b1) begin
            errors++; $display("FAIL sh_read: got %b required 1", mem_read);
        end
        step();
        checks++;
        if ({mem_write, mem_wdata} !== {1'b1, 32'h1234_CCDD}) begin
            errors++; $display("FAIL sh_write: wr=%b wdata=%h required 1 1234ccdd", mem_write, mem_wdata);
        end
        step();
        checks++;
        if (mem[5] !== 32'h1234_CCDD) begin
            errors++; $display("FAIL sh_mem_commit: got %h required 1234ccdd", mem[5]);
        end
        // Misaligned halfword: consumed, flagged, never queued.
        drive(SH, 32'h15, 32'h0000_5678);
        step();
        idle_req();
        checks++;
        if ({misalign_err, busy, req_ready} !== 3'b101) begin
            errors++; $display("FAIL sh_misalign: err,busy,ready=%b required 101", {misalign_err, busy, req_ready});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({mem_read, mem_write, busy, misalign_err} !== 4'b0000) begin
                errors++; $display("FAIL sh_misalign_quiet: rd,wr,busy,err=%b required 0000 (cycle %0d)",
                                   {mem_read, mem_write, busy, misalign_err}, i);
            end
        end
        checks++;
        if (mem[5] !== 32'h1234_CCDD) begin
            errors++; $display("FAIL sh_misalign_mem: got %h required 1234ccdd", mem[5]);
        end
    endtask

    task automatic test_sw();
        drive(SW, 32'h20, 32'hDEAD_BEEF);
        step();  // E0
        idle_req();
        checks++;
        if ({busy, mem_write, mem_read} !== 3'b100) begin
            errors++; $display("FAIL sw_accept: busy,wr,rd=%b required 100", {busy, mem_write, mem_read});
        end
        step();  // E1: WRITE directly
        checks++;
        if ({mem_read, mem_write, mem_address, mem_wdata} !== {2'b01, 32'h20, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL sw_write: rd=%b wr=%b addr=%h wdata=%h required 0 1 00000020 deadbeef",
                               mem_read, mem_write, mem_address, mem_wdata);
        end
        step();  // E2
        checks++;
        if ({mem[8], busy} !== {32'hDEAD_BEEF, 1'b0}) begin
            errors++; $display("FAIL sw_mem_commit: mem=%h busy=%b required deadbeef 0", mem[8], busy);
        end
        drive(SW, 32'h22, 32'h0BAD_0BAD);
        step();
        idle_req();
        checks++;
        if ({misalign_err, busy} !== 2'b10) begin
            errors++; $display("FAIL sw_misalign: err,busy=%b required 10", {misalign_err, busy});
        end
        step();
        step();
        checks++;
        if ({mem[8], mem_write} !== {32'hDEAD_BEEF, 1'b0}) begin
            errors++; $display("FAIL sw_misalign_mem: mem=%h wr=%b required deadbeef 0", mem[8], mem_write);
        end
    endtask

    task automatic test_back_to_back();
        drive(SW, 32'h30, 32'h3030_3030);
        step();  // E0: first accepted
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_after_one: got %b required 1", req_ready);
        end
        drive(SW, 32'h34, 32'h3434_3434);
        step();  // E1: second accepted, queue full, head in WRITE
        checks++;
        if ({req_ready, mem_write, mem_address} !== {2'b01, 32'h30}) begin
            errors++; $display("FAIL b2b_full: ready=%b wr=%b addr=%h required 0 1 00000030", req_ready, mem_write, mem_address);
        end
        drive(SW, 32'h38, 32'h3838_3838);
        step();  // E2: pop; third not taken because ready was low
        checks++;
        if ({req_ready, mem_write} !== 2'b10) begin
            errors++; $display("FAIL b2b_after_pop: ready=%b wr=%b required 1 0", req_ready, mem_write);
        end
        step();  // E3: third accepted, second in WRITE
        idle_req();
        checks++;
        if ({req_ready, mem_write, mem_address} !== {2'b01, 32'h34}) begin
            errors++; $display("FAIL b2b_second_write: ready=%b wr=%b addr=%h required 0 1 00000034", req_ready, mem_write, mem_address);
        end
        step();  // E4
        step();  // E5: third in WRITE
        checks++;
        if ({busy, mem_write, mem_address} !== {2'b11, 32'h38}) begin
            errors++; $display("FAIL b2b_third_write: busy=%b wr=%b addr=%h required 1 1 00000038", busy, mem_write, mem_address);
        end
        step();  // E6
        checks++;
        if ({busy, mem[12], mem[13], mem[14]} !== {1'b0, 32'h3030_3030, 32'h3434_3434, 32'h3838_3838}) begin
            errors++; $display("FAIL b2b_final: busy=%b mem=%h %h %h required 0 30303030 34343434 38383838",
                               busy, mem[12], mem[13], mem[14]);
        end
    endtask

    task automatic test_chk_hit();
        chk_address = 32'h40;
        drive(SB, 32'h41, 32'h0000_0055);
        step();  // E0: entry pending
        idle_req();
        checks++;
        if (chk_hit !== 1'b1) begin
            errors++; $display("FAIL chk_hit_queued: got %b required 1", chk_hit);
        end
        chk_address = 32'h44;
        #1;
        checks++;
        if (chk_hit !== 1'b0) begin
            errors++; $display("FAIL chk_miss_next_word: got %b required 0", chk_hit);
        end
        chk_address = 32'h43;
        step();  // E1: READ
        checks++;
        if ({chk_hit, mem_read} !== 2'b11) begin
            errors++; $display("FAIL chk_hit_read: hit,rd=%b required 11", {chk_hit, mem_read});
        end
        step();  // E2: WRITE
        checks++;
        if ({chk_hit, mem_wdata} !== {1'b1, 32'h0000_5500}) begin
            errors++; $display("FAIL chk_hit_write: hit=%b wdata=%h required 1 00005500", chk_hit, mem_wdata);
        end
        step();  // E3: popped
        checks++;
        if (chk_hit !== 1'b0) begin
            errors++; $display("FAIL chk_hit_clear: got %b required 0", chk_hit);
        end
        chk_address = 32'h0;
    endtask

    task automatic test_reset_midflight();
        drive(SB, 32'h48, 32'h0000_00FF);
        step();
        idle_req();
        step();  // READ of the pending SB
        checks++;
        if (mem_read !== 1'b1) begin
            errors++; $display("FAIL rst_mid_read: got %b required 1", mem_read);
        end
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid_async");
        step();
        step();
        reset = 1'b0;
        step();
        check_reset_outputs("rst_mid_after");
        checks++;
        if (mem[18] !== 32'h0102_0304) begin
            errors++; $display("FAIL rst_mid_mem: got %h required 01020304", mem[18]);
        end
        drive(SW, 32'h4C, 32'hCAFE_F00D);
        step();
        idle_req();
        step();
        checks++;
        if ({mem_write, mem_address, mem_wdata} !== {1'b1, 32'h4C, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL rst_mid_sw_write: wr=%b addr=%h wdata=%h required 1 0000004c cafef00d",
                               mem_write, mem_address, mem_wdata);
        end
        step();
        checks++;
        if ({mem[19], mem[18], busy} !== {32'hCAFE_F00D, 32'h0102_0304, 1'b0}) begin
            errors++; $display("FAIL rst_mid_sw_commit: mem19=%h mem18=%h busy=%b required cafef00d 01020304 0",
                               mem[19], mem[18], busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h1122_3344;
        mem[5]  = 32'hAABB_CCDD;
        mem[18] = 32'h0102_0304;
        test_reset();
        test_sb();
        test_sh();
        test_sw();
        test_back_to_back();
        test_chk_hit();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_store_unit.md
Name: data_mem_store_unit

Overview:
Store-side companion to the data memory's load path. It accepts SB/SH/SW requests from the CPU datapath and buffers them in a small posted-store queue. It drains the queue into the word-addressed data memory, using read-modify-write for sub-word stores and a direct write for SW. It also flags misaligned stores and reports queue address hits so the CPU can stall dependent loads.

Parameters:
QUEUE_DEPTH, 2, number of posted store entries (power of two, >=2)
ADDR_W, 32, byte address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  store request present
req_ready  output  1  queue can accept (count < QUEUE_DEPTH)
req_opcode  input  6  MIPS opcode: 0x28 SB, 0x29 SH, 0x2B SW
req_address  input  ADDR_W  byte address
req_data  input  32  rt value; SB uses [7:0], SH uses [15:0]
mem_address  output  ADDR_W  word-aligned address {head[31:2],2'b00}
mem_read  output  1  word read strobe; mem_rdata is valid in the same cycle
mem_rdata  input  32  combinational read data from the data memory
mem_write  output  1  write strobe; memory commits on the next rising clk
mem_wdata  output  32  merged word
chk_address  input  ADDR_W  load address to check against pending stores
chk_hit  output  1  combinational; any valid entry has word address == chk_address[31:2]
busy  output  1  queue non-empty or FSM not IDLE
misalign_err  output  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (async, any state): queue emptied, FSM to IDLE.
- Reset values: req_ready=1, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, chk_hit=0, busy=0, misalign_err=0.
- A store interrupted by reset is dropped; memory is untouched unless mem_write was already sampled.
- Handshake: a transfer occurs on a rising edge with req_valid && req_ready. req_ready depends only on count, with no same-cycle pop bypass; when full, req_ready=0 even if a pop occurs that cycle.
- Alignment rules: SH needs address[0]==0; SW needs address[1:0]==0.
- A misaligned request or any other opcode is consumed (handshake completes), not enqueued, and misalign_err=1 in the cycle after the edge.
- Entry contents: word address [31:2], byte-enable mask[3:0], lane-aligned data[31:0]. Lane k = bits [8k+7:8k], little-endian, matching LB/LH on the load side.
  - SB: mask = 1<<address[1:0]; data byte replicated to all lanes.
  - SH: mask = address[1] ? 4'b1100 : 4'b0011; halfword replicated to both halves.
  - SW: mask = 4'b1111.
- FSM states:
  - IDLE: queue empty -> stay. Head mask==1111 -> WRITE. Otherwise -> READ.
  - READ (1 cycle): mem_read=1, mem_address=head; capture mem_rdata into merge_reg -> WRITE.
  - WRITE (1 cycle): mem_write=1; mem_wdata = mask lanes from entry, others from merge_reg (SW: entry data); pop head at end of cycle -> IDLE.
- Latency from the accept edge E0:
  - SW: WRITE during cycle E1–E2; memory updated at E2.
  - SB/SH: READ during E1–E2, WRITE during E2–E3; memory updated at E3.
- Throughput: one SW per 2 cycles, one sub-word store per 3 cycles.
- The queue is in-order. Pointers wrap modulo QUEUE_DEPTH. count has width clog2(QUEUE_DEPTH)+1.
- Simultaneous push and pop: count unchanged.
- Pop when empty cannot occur (FSM guards); push when full is blocked by req_ready.
- mem_read and mem_write are never asserted together.
- chk_hit covers all valid entries, including the head in READ or WRITE. It is independent of the byte mask; the CPU stalls loads on hit.

Decomposition:
- Shared package mips_mem_pkg:
  - Opcode constants OP_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - Typedef store_entry_t {word_addr[29:0], mask[3:0], data[31:0]}.
  - State enum.
  - Function lane_merge(old, new, mask).
- One sub-module: store_queue, a parameterised synchronous FIFO of store_entry_t with full/empty/count. It also exposes the entry array so chk_hit comparators can be built in the parent.

Test Plan:
- Memory word 0x10 = 0x11223344; SB addr 0x12 data 0x000000AB -> READ then WRITE; mem_wdata=0x11AB3344, word 0x10 updated at E3; misalign_err=0.
- Word 0x14 = 0xAABBCCDD; SH addr 0x16 data 0x00001234 -> mem_wdata=0x1234CCDD. SH addr 0x15 -> misalign_err pulse, no mem_read or mem_write, busy stays 0.
- SW addr 0x20 data 0xDEADBEEF -> no READ state, mem_write in cycle E1 with mem_wdata=0xDEADBEEF. SW addr 0x22 -> misalign_err, no write.
- Three back-to-back SW (0x30, 0x34, 0x38) with req_valid held -> first two accepted, req_ready=0 until the first pop, writes issued in order, busy falls after the third write.
- Queue holds SB to 0x41; chk_address=0x40 -> chk_hit=1; chk_address=0x44 -> chk_hit=0; chk_hit clears the cycle after the WRITE pop.
- Assert reset during the READ of a pending SB -> all outputs return to their reset values immediately. Memory is unchanged, the queue is empty, and a new SW accepted after reset completes normally.
